// File: rtl/nncore_pkg.sv
// Shared types for the neuromorphic core datapath.
// Holds the default geometry of a spike encoder and the address-event word
// layout that both the spike encoder and the downstream event router use.
package nncore_pkg;

  localparam int NUM_COLS_DEF = 16;
  localparam int ADDR_W_DEF   = $clog2(NUM_COLS_DEF);
  localparam int TS_W_DEF     = 8;
  localparam int DROP_W_DEF   = 16;

  typedef logic [ADDR_W_DEF-1:0] col_addr_t;
  typedef logic [TS_W_DEF-1:0]   timestep_t;

  // One address-event word: which column fired and in which timestep.
  typedef struct packed {
    col_addr_t addr;
    timestep_t ts;
  } spike_event_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational request picker.
// Searches req starting at index 'start' (round-robin) or at index 0 (fixed
// priority), wrapping from NUM_COLS-1 back to 0, and returns the first set bit.
// Ports:
//   req         : request vector, one bit per column
//   start       : first index searched when ROUND_ROBIN != 0
//   grant_valid : at least one request is set
//   grant_idx   : index of the selected request (0 when none)
module rr_priority_pick
  import nncore_pkg::*;
#(
  parameter int NUM_COLS    = NUM_COLS_DEF,
  parameter int ROUND_ROBIN = 1,
  parameter int ADDR_W      = $clog2(NUM_COLS)
) (
  input  logic [NUM_COLS-1:0] req,
  input  logic [ADDR_W-1:0]   start,
  output logic                grant_valid,
  output logic [ADDR_W-1:0]   grant_idx
);

  logic [ADDR_W-1:0] base_s;

  // Fixed priority is simply a round-robin search that always starts at 0.
  always_comb begin
    if (ROUND_ROBIN != 0) begin
      base_s = start;
    end else begin
      base_s = '0;
    end
  end

  // Walk the request vector from the base index, first hit wins.
  always_comb begin
    int                idx_v;
    logic [ADDR_W-1:0] idx_a;
    idx_v       = 0;
    idx_a       = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_COLS; k++) begin
      idx_v = (int'(base_s) + k) % NUM_COLS;
      idx_a = ADDR_W'(idx_v);
      if (!grant_valid && req[idx_a]) begin
        grant_valid = 1'b1;
        grant_idx   = idx_a;
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

endmodule

// File: rtl/spike_priority_encoder.sv
// Spike priority encoder.
// Captures single-cycle spike pulses from the neuron columns into a pending
// register, tags each with the timestep it arrived in, and serialises them as
// address-event words over a valid/ready handshake toward the event router.
// Ports:
//   main_clk, main_rst_n : clock, asynchronous active-low reset
//   spike_i              : spike pulse per column, sampled every rising edge
//   tick_i               : timestep advance strobe
//   flush_i              : synchronous clear of pending spikes and output word
//   ev_valid_o/ev_ready_i: event handshake
//   ev_addr_o, ev_ts_o   : event column and spike timestep
//   timestep_o           : current timestep counter
//   drop_cnt_o           : saturating count of spikes lost to collisions
//   busy_o               : pending spikes or an event on the output
module spike_priority_encoder
  import nncore_pkg::*;
#(
  parameter int NUM_COLS    = NUM_COLS_DEF,
  parameter int ADDR_W      = $clog2(NUM_COLS),
  parameter int TS_W        = TS_W_DEF,
  parameter int ROUND_ROBIN = 1,
  parameter int DROP_W      = DROP_W_DEF
) (
  input  logic                main_clk,
  input  logic                main_rst_n,
  input  logic [NUM_COLS-1:0] spike_i,
  input  logic                tick_i,
  input  logic                flush_i,
  output logic                ev_valid_o,
  input  logic                ev_ready_i,
  output logic [ADDR_W-1:0]   ev_addr_o,
  output logic [TS_W-1:0]     ev_ts_o,
  output logic [TS_W-1:0]     timestep_o,
  output logic [DROP_W-1:0]   drop_cnt_o,
  output logic                busy_o
);

  localparam int CNT_W = $clog2(NUM_COLS + 1);
  localparam int SUM_W = DROP_W + 1;

  logic [NUM_COLS-1:0] pending_r;
  logic [NUM_COLS-1:0] pending_nxt_s;
  logic [TS_W-1:0]     ts_store_r     [NUM_COLS];
  logic [TS_W-1:0]     ts_store_nxt_s [NUM_COLS];
  logic [ADDR_W-1:0]   rr_ptr_r;
  logic [ADDR_W-1:0]   rr_ptr_nxt_s;
  logic                ev_valid_nxt_s;
  logic [ADDR_W-1:0]   ev_addr_nxt_s;
  logic [TS_W-1:0]     ev_ts_nxt_s;
  logic [TS_W-1:0]     timestep_nxt_s;
  logic [DROP_W-1:0]   drop_nxt_s;
  logic [SUM_W-1:0]    drop_sum_s;
  logic                busy_nxt_s;
  logic                load_s;
  logic                gnt_valid_s;
  logic [ADDR_W-1:0]   gnt_idx_s;
  logic [NUM_COLS-1:0] gnt_vec_s;
  logic [CNT_W-1:0]    coll_cnt_s;

  rr_priority_pick #(
    .NUM_COLS    (NUM_COLS),
    .ROUND_ROBIN (ROUND_ROBIN),
    .ADDR_W      (ADDR_W)
  ) u_pick (
    .req         (pending_r),
    .start       (rr_ptr_r),
    .grant_valid (gnt_valid_s),
    .grant_idx   (gnt_idx_s)
  );

  // The output word may be replaced when it is empty or being accepted now.
  always_comb begin
    load_s = !ev_valid_o || ev_ready_i;
  end

  // One-hot of the column handed to the output register this cycle.
  always_comb begin
    gnt_vec_s = '0;
    if (load_s && gnt_valid_s && !flush_i) begin
      gnt_vec_s[gnt_idx_s] = 1'b1;
    end else begin
      gnt_vec_s = '0;
    end
  end

  // Spike capture: a column being granted this cycle frees its slot, so a
  // same-cycle spike is re-captured rather than counted as a collision.
  always_comb begin
    pending_nxt_s  = pending_r & ~gnt_vec_s;
    ts_store_nxt_s = ts_store_r;
    coll_cnt_s     = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (spike_i[c] && (!pending_r[c] || gnt_vec_s[c])) begin
        pending_nxt_s[c]  = 1'b1;
        ts_store_nxt_s[c] = timestep_o;
      end else if (spike_i[c]) begin
        coll_cnt_s = coll_cnt_s + CNT_W'(1);
      end else begin
        pending_nxt_s[c] = pending_nxt_s[c];
      end
    end
    if (flush_i) begin
      pending_nxt_s = '0;
      coll_cnt_s    = '0;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
  end

  // Drop counter adds all collisions of the cycle and sticks at all-ones.
  always_comb begin
    drop_sum_s = {1'b0, drop_cnt_o} + SUM_W'(coll_cnt_s);
    if (drop_sum_s[DROP_W]) begin
      drop_nxt_s = '1;
    end else begin
      drop_nxt_s = drop_sum_s[DROP_W-1:0];
    end
  end

  // Output word, arbitration pointer and timestep next-state.
  always_comb begin
    ev_valid_nxt_s = ev_valid_o;
    ev_addr_nxt_s  = ev_addr_o;
    ev_ts_nxt_s    = ev_ts_o;
    rr_ptr_nxt_s   = rr_ptr_r;
    if (flush_i) begin
      ev_valid_nxt_s = 1'b0;
    end else if (load_s && gnt_valid_s) begin
      ev_valid_nxt_s = 1'b1;
      ev_addr_nxt_s  = gnt_idx_s;
      ev_ts_nxt_s    = ts_store_r[gnt_idx_s];
      if (gnt_idx_s == ADDR_W'(NUM_COLS - 1)) begin
        rr_ptr_nxt_s = '0;
      end else begin
        rr_ptr_nxt_s = gnt_idx_s + ADDR_W'(1);
      end
    end else if (load_s) begin
      ev_valid_nxt_s = 1'b0;
    end else begin
      ev_valid_nxt_s = ev_valid_o;
    end
    if (tick_i) begin
      timestep_nxt_s = timestep_o + TS_W'(1);
    end else begin
      timestep_nxt_s = timestep_o;
    end
    busy_nxt_s = (|pending_nxt_s) | ev_valid_nxt_s;
  end

  // State and output registers.
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      pending_r  <= '0;
      rr_ptr_r   <= '0;
      ev_valid_o <= 1'b0;
      ev_addr_o  <= '0;
      ev_ts_o    <= '0;
      timestep_o <= '0;
      drop_cnt_o <= '0;
      busy_o     <= 1'b0;
      for (int c = 0; c < NUM_COLS; c++) begin
        ts_store_r[c] <= '0;
      end
    end else begin
      pending_r  <= pending_nxt_s;
      rr_ptr_r   <= rr_ptr_nxt_s;
      ev_valid_o <= ev_valid_nxt_s;
      ev_addr_o  <= ev_addr_nxt_s;
      ev_ts_o    <= ev_ts_nxt_s;
      timestep_o <= timestep_nxt_s;
      drop_cnt_o <= drop_nxt_s;
      busy_o     <= busy_nxt_s;
      for (int c = 0; c < NUM_COLS; c++) begin
        ts_store_r[c] <= ts_store_nxt_s[c];
      end
    end
  end

endmodule

// File: tb/tb_spike_priority_encoder.sv
// Bench for spike_priority_encoder: one fixed-priority and one round-robin
// instance share stimulus; a reference model predicts the event stream into
// per-instance queues that a negedge monitor drains and compares.
module tb_spike_priority_encoder;

  localparam int NC   = 8;
  localparam int TSM  = 256;
  localparam int DMAX = 65535;

  logic          main_clk   = 1'b0;
  logic          main_rst_n = 1'b1;
  logic [NC-1:0] spike_i    = '0;
  logic          tick_i     = 1'b0;
  logic          flush_i    = 1'b0;
  logic          ev_ready_i = 1'b0;

  logic          ev_valid [2];
  logic [2:0]    ev_addr  [2];
  logic [7:0]    ev_ts    [2];
  logic [7:0]    tstep    [2];
  logic [15:0]   drop     [2];
  logic          busy     [2];

  always #5 main_clk = ~main_clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    spike_priority_encoder #(
      .NUM_COLS    (NC),
      .ADDR_W      (3),
      .TS_W        (8),
      .ROUND_ROBIN (g),
      .DROP_W      (16)
    ) u_dut (
      .main_clk   (main_clk),
      .main_rst_n (main_rst_n),
      .spike_i    (spike_i),
      .tick_i     (tick_i),
      .flush_i    (flush_i),
      .ev_valid_o (ev_valid[g]),
      .ev_ready_i (ev_ready_i),
      .ev_addr_o  (ev_addr[g]),
      .ev_ts_o    (ev_ts[g]),
      .timestep_o (tstep[g]),
      .drop_cnt_o (drop[g]),
      .busy_o     (busy[g])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (instance 0: lowest index wins, instance 1: round robin)
  int q0[$];
  int q1[$];
  bit m_pend  [2][NC];
  int m_tst   [2][NC];
  bit m_valid [2];
  int m_ptr   [2];
  int m_drop  [2];
  int m_ts;

  task automatic check(input string name, input int g, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d, expected %0d at %0t", name, g, act, exp, $time);
    end
  endtask

  function automatic int q_size(input int g);
    return (g == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int q_front(input int g);
    return (g == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void q_push(input int g, input int v);
    if (g == 0) q0.push_back(v); else q1.push_back(v);
  endfunction

  function automatic void q_pop(input int g);
    if (g == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endfunction

  function automatic void q_pop_back(input int g);
    if (g == 0) void'(q0.pop_back()); else void'(q1.pop_back());
  endfunction

  task automatic model_reset();
    for (int g = 0; g < 2; g++) begin
      m_valid[g] = 1'b0;
      m_ptr[g]   = 0;
      m_drop[g]  = 0;
      for (int c = 0; c < NC; c++) begin
        m_pend[g][c] = 1'b0;
        m_tst[g][c]  = 0;
      end
    end
    q0.delete();
    q1.delete();
    m_ts = 0;
  endtask

  // Advance the model by one clock edge with the inputs sampled at that edge.
  task automatic model_step(input logic [NC-1:0] sp, input bit tk, input bit fl, input bit rd);
    for (int g = 0; g < 2; g++) begin
      bit load;
      int win;
      int drops;
      if (fl) begin
        if (m_valid[g] && !rd) q_pop_back(g);
        m_valid[g] = 1'b0;
        for (int c = 0; c < NC; c++) m_pend[g][c] = 1'b0;
      end else begin
        load = !m_valid[g] || rd;
        win  = -1;
        if (load) begin
          for (int k = 0; k < NC; k++) begin
            int c;
            c = (g == 1) ? (m_ptr[g] + k) % NC : k;
            if (win < 0 && m_pend[g][c]) win = c;
          end
        end
        if (load && win >= 0) begin
          q_push(g, win * 256 + m_tst[g][win]);
          m_pend[g][win] = 1'b0;
          m_ptr[g]       = (win + 1) % NC;
          m_valid[g]     = 1'b1;
        end else if (load) begin
          m_valid[g] = 1'b0;
        end
        drops = 0;
        for (int c = 0; c < NC; c++) begin
          if (sp[c]) begin
            if (!m_pend[g][c]) begin
              m_pend[g][c] = 1'b1;
              m_tst[g][c]  = m_ts;
            end else begin
              drops++;
            end
          end
        end
        m_drop[g] = (m_drop[g] + drops > DMAX) ? DMAX : m_drop[g] + drops;
      end
    end
    m_ts = (m_ts + int'(tk)) % TSM;
  endtask

  // Called at posedge+1: drive one cycle of inputs, step model at the edge.
  task automatic step(input logic [NC-1:0] sp, input bit tk, input bit fl, input bit rd);
    spike_i    = sp;
    tick_i     = tk;
    flush_i    = fl;
    ev_ready_i = rd;
    @(posedge main_clk);
    model_step(sp, tk, fl, rd);
    #1;
    spike_i = '0;
    tick_i  = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int g = 0; g < 2; g++) begin
      check({tag, "_valid"}, g, int'(ev_valid[g]), 0);
      check({tag, "_addr"},  g, int'(ev_addr[g]), 0);
      check({tag, "_ts"},    g, int'(ev_ts[g]), 0);
      check({tag, "_tstep"}, g, int'(tstep[g]), 0);
      check({tag, "_drop"},  g, int'(drop[g]), 0);
      check({tag, "_busy"},  g, int'(busy[g]), 0);
    end
  endtask

  // Monitor: compare status every cycle and each presented event to the queue.
  always @(negedge main_clk) begin
    for (int g = 0; g < 2; g++) begin
      bit mb;
      mb = m_valid[g];
      for (int c = 0; c < NC; c++) if (m_pend[g][c]) mb = 1'b1;
      check("ev_valid", g, int'(ev_valid[g]), int'(m_valid[g]));
      check("timestep", g, int'(tstep[g]), m_ts);
      check("drop_cnt", g, int'(drop[g]), m_drop[g]);
      check("busy",     g, int'(busy[g]), int'(mb));
      if (ev_valid[g] === 1'b1) begin
        check("evq_depth", g, q_size(g), 1);
        if (q_size(g) > 0) begin
          check("ev_addr", g, int'(ev_addr[g]), q_front(g) / 256);
          check("ev_ts",   g, int'(ev_ts[g]), q_front(g) % 256);
          if (ev_ready_i) q_pop(g);
        end
      end
    end
  end

  initial begin
    int t0;
    int cnt;
    model_reset();
    #2 main_rst_n = 1'b0;
    #1 check_all_zero("reset");
    @(posedge main_clk);
    @(posedge main_clk);
    #1 main_rst_n = 1'b1;

    // Three ticks to timestep 3, then columns 2, 5, 7 spike together
    repeat (3) step('0, 1'b1, 1'b0, 1'b1);
    step(8'b1010_0100, 1'b0, 1'b0, 1'b1);
    repeat (6) step('0, 1'b0, 1'b0, 1'b1);

    // All columns spiking continuously
    repeat (20) step(8'hFF, 1'b0, 1'b0, 1'b1);
    repeat (10) step('0, 1'b0, 1'b0, 1'b1);

    // Backpressure with column 4 on the output, two ticks meanwhile
    step(8'h10, 1'b0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0);
    repeat (4) step('0, 1'b0, 1'b0, 1'b1);

    // Collision: column 1 re-spikes while still pending behind a stalled output
    step(8'h01, 1'b0, 1'b0, 1'b0);
    step(8'h02, 1'b0, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0);
    step(8'h02, 1'b0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0);
    repeat (5) step('0, 1'b0, 1'b0, 1'b1);

    // Column 6 spikes again in the cycle its pending bit is granted
    step(8'h40, 1'b0, 1'b0, 1'b1);
    step(8'h40, 1'b0, 1'b0, 1'b1);
    repeat (4) step('0, 1'b0, 1'b0, 1'b1);

    // Flush with a stalled output and same-cycle spikes
    step(8'hF0, 1'b0, 1'b0, 1'b0);
    step(8'h0F, 1'b0, 1'b0, 1'b0);
    step(8'hFF, 1'b1, 1'b1, 1'b0);
    repeat (4) step('0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(NC'($urandom & $urandom), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0));
    end
    repeat (12) step('0, 1'b0, 1'b0, 1'b1);

    // Timestep wrap: 256 ticks return to the starting value
    t0 = m_ts;
    repeat (256) step('0, 1'b1, 1'b0, 1'b1);
    for (int g = 0; g < 2; g++) check("ts_wrap", g, int'(tstep[g]), t0);

    // Drive the drop counter into saturation
    cnt = 0;
    while ((m_drop[0] < DMAX || m_drop[1] < DMAX) && cnt < 20000) begin
      step(8'hFF, 1'b0, 1'b0, ($urandom_range(0, 3) != 0));
      cnt++;
    end
    check("sat_budget", 0, int'(cnt < 20000), 1);
    repeat (5) step(8'hFF, 1'b0, 1'b0, 1'b0);
    for (int g = 0; g < 2; g++) check("drop_sat", g, int'(drop[g]), DMAX);

    // Reset while an unaccepted event is on the output
    step(8'hFF, 1'b1, 1'b0, 1'b0);
    for (int g = 0; g < 2; g++) check("pre_reset_valid", g, int'(ev_valid[g]), 1);
    main_rst_n = 1'b0;
    model_reset();
    #1 check_all_zero("midreset");
    @(posedge main_clk);
    #1 main_rst_n = 1'b1;
    repeat (6) step('0, 1'b0, 1'b0, 1'b1);
    step(8'h81, 1'b0, 1'b0, 1'b1);
    repeat (6) step('0, 1'b0, 1'b0, 1'b1);

    for (int g = 0; g < 2; g++) begin
      check("drain_queue", g, q_size(g), 0);
      check("drain_busy",  g, int'(busy[g]), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
